regfile_write_queue: RTL

- Writer-side front end for the 16x16 register file (ports we/A3/wd).
- Accepts register writebacks from two producers, the ALU and the load unit, through valid/ready handshakes.
- Buffers pending writes in a small FIFO and drains one write per cycle into the register file's single write port.
- Forwards pending (not yet written) data to two read-address queries, so decode never sees stale values.

---
 rtl/regfile_write_queue_pkg.sv | 16 +
 rtl/regfile_wq_fifo.sv | 83 ++++++++
 rtl/regfile_write_queue.sv | 121 ++++++++++++
 3 files changed

// File: rtl/regfile_write_queue_pkg.sv
// Shared constants and types for the register-file write queue.
//   DATA_W      - register data width
//   ADDR_W      - register address width
//   RF_NUM_REGS - number of architectural registers
//   wb_entry_t  - one pending writeback {valid, addr, data}
package rf_pkg;
    localparam int DATA_W      = 16;
    localparam int ADDR_W      = 4;
    localparam int RF_NUM_REGS = 1 << ADDR_W;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/regfile_wq_fifo.sv
// Pending-write storage for regfile_write_queue.
// DEPTH-entry circular buffer with a per-entry valid bit, so the forwarding
// logic can scan every slot without decoding the pointer window itself.
// Ports:
//   clk, rst                   - clock, async active-high reset
//   i_push, i_push_addr/data   - enqueue one entry (caller guarantees !o_full)
//   i_pop                      - retire the head (caller guarantees !o_empty)
//   o_empty, o_full            - occupancy flags
//   o_head_addr, o_head_data   - oldest entry
//   o_rptr                     - head index (age origin for forwarding)
//   o_vld, o_addr, o_data      - raw entry array view
module regfile_wq_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = rf_pkg::DATA_W,
    parameter int ADDR_W = rf_pkg::ADDR_W
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_push,
    input  logic [ADDR_W-1:0]                i_push_addr,
    input  logic [DATA_W-1:0]                i_push_data,
    input  logic                             i_pop,
    output logic                             o_empty,
    output logic                             o_full,
    output logic [ADDR_W-1:0]                o_head_addr,
    output logic [DATA_W-1:0]                o_head_data,
    output logic [$clog2(DEPTH)-1:0]         o_rptr,
    output logic [DEPTH-1:0]                 o_vld,
    output logic [DEPTH-1:0][ADDR_W-1:0]     o_addr,
    output logic [DEPTH-1:0][DATA_W-1:0]     o_data
);
    import rf_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]             r_wptr, r_rptr;
    logic [CNT_W-1:0]             r_count;
    logic [DEPTH-1:0]             r_vld;
    logic [DEPTH-1:0][ADDR_W-1:0] r_addr;
    logic [DEPTH-1:0][DATA_W-1:0] r_data;

    // Control state; pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_vld   <= '0;
        end else begin
            if (i_push) begin
                r_vld[r_wptr] <= 1'b1;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (i_pop) begin
                r_vld[r_rptr] <= 1'b0;
                r_rptr        <= r_rptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload is qualified by r_vld, so it needs no reset.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_addr[r_wptr] <= i_push_addr;
            r_data[r_wptr] <= i_push_data;
        end
    end

    assign o_empty     = (r_count == '0);
    assign o_full      = (r_count == CNT_W'(DEPTH));
    assign o_head_addr = r_addr[r_rptr];
    assign o_head_data = r_data[r_rptr];
    assign o_rptr      = r_rptr;
    assign o_vld       = r_vld;
    assign o_addr      = r_addr;
    assign o_data      = r_data;
endmodule

// File: rtl/regfile_write_queue.sv
// Writer-side front end for the 16x16 register file.
// Arbitrates ALU / load-unit writebacks (load unit wins), buffers them in a
// DEPTH-entry FIFO, drains one per cycle into the RF write port (we/A3/wd)
// and forwards the youngest pending value to two read queries.
// Ports:
//   clk, rst                          - clock, async active-high reset
//   mem_valid/rd/data, mem_ready      - load-unit writeback handshake
//   alu_valid/rd/data, alu_ready      - ALU writeback handshake
//   wr_hold                           - stall draining
//   we, A3, wd                        - register-file write port
//   q1_addr/q2_addr -> q*_hit/q*_data - forwarding queries
//   empty                             - no pending writes
// Build option: define RF_ZERO_REG_EN to hardwire register 0 to zero.
module regfile_write_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = rf_pkg::DATA_W,
    parameter int ADDR_W = rf_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              wr_hold,
    output logic              we,
    output logic [ADDR_W-1:0] A3,
    output logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] q1_addr,
    input  logic [ADDR_W-1:0] q2_addr,
    output logic              q1_hit,
    output logic              q2_hit,
    output logic [DATA_W-1:0] q1_data,
    output logic [DATA_W-1:0] q2_data,
    output logic              empty
);
    import rf_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);

    logic                         w_empty, w_full, w_push, w_mem_fire, w_alu_fire;
    logic [ADDR_W-1:0]            w_enq_addr, w_head_addr;
    logic [DATA_W-1:0]            w_enq_data, w_head_data;
    logic [PTR_W-1:0]             w_rptr;
    logic [DEPTH-1:0]             w_vld;
    logic [DEPTH-1:0][ADDR_W-1:0] w_addr;
    logic [DEPTH-1:0][DATA_W-1:0] w_data;
    logic [DATA_W:0]              w_q1, w_q2;

    // Ready ignores a same-cycle drain to keep it off the wr_hold path.
    assign mem_ready  = !w_full;
    assign alu_ready  = !w_full && !mem_valid;
    assign w_mem_fire = mem_valid && mem_ready;
    assign w_alu_fire = alu_valid && alu_ready;
    assign w_enq_addr = w_mem_fire ? mem_rd   : alu_rd;
    assign w_enq_data = w_mem_fire ? mem_data : alu_data;

`ifdef RF_ZERO_REG_EN
    // r0 writes complete the handshake but are dropped.
    assign w_push = (w_mem_fire || w_alu_fire) && (w_enq_addr != '0);
`else
    assign w_push = w_mem_fire || w_alu_fire;
`endif

    regfile_wq_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_addr (w_enq_addr),
        .i_push_data (w_enq_data),
        .i_pop       (we),
        .o_empty     (w_empty),
        .o_full      (w_full),
        .o_head_addr (w_head_addr),
        .o_head_data (w_head_data),
        .o_rptr      (w_rptr),
        .o_vld       (w_vld),
        .o_addr      (w_addr),
        .o_data      (w_data)
    );

    assign empty = w_empty;
    assign we    = !w_empty && !wr_hold;
    assign A3    = we ? w_head_addr : '0;
    assign wd    = we ? w_head_data : '0;

    // Walk slots oldest->youngest starting at the head; a later match
    // overwrites an earlier one, so the youngest matching entry wins.
    function automatic logic [DATA_W:0] fwd(
        input logic [ADDR_W-1:0]            q,
        input logic [DEPTH-1:0]             v,
        input logic [DEPTH-1:0][ADDR_W-1:0] a,
        input logic [DEPTH-1:0][DATA_W-1:0] d,
        input logic [PTR_W-1:0]             rp
    );
        logic [PTR_W-1:0] idx;
        logic [DATA_W:0]  res;
        res = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rp + PTR_W'(k);
            if (v[idx] && (a[idx] == q))
                res = {1'b1, d[idx]};
        end
`ifdef RF_ZERO_REG_EN
        if (q == '0)
            res = {1'b1, {DATA_W{1'b0}}};
`endif
        return res;
    endfunction

    assign w_q1    = fwd(q1_addr, w_vld, w_addr, w_data, w_rptr);
    assign w_q2    = fwd(q2_addr, w_vld, w_addr, w_data, w_rptr);
    assign q1_hit  = w_q1[DATA_W];
    assign q1_data = w_q1[DATA_W-1:0];
    assign q2_hit  = w_q2[DATA_W];
    assign q2_data = w_q2[DATA_W-1:0];
endmodule
